// File: rtl/masked_share_compress_if.sv
// Handshake and share bus between the masked coordinate functions, this
// compressor and the next S-box stage.
interface masked_share_compress_if #(
  parameter int CNT_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [26:0]      exp_cf0;
  logic [26:0]      exp_cf1;
  logic [8:0]       exp_cf2;
  logic [8:0]       exp_cf3;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_sh;
  logic [CNT_W-1:0] acc_cnt;

  modport slave (
    input  flush, in_valid, exp_cf0, exp_cf1, exp_cf2, exp_cf3, out_ready,
    output in_ready, out_valid, out_sh, acc_cnt
  );

  modport master (
    output flush, in_valid, exp_cf0, exp_cf1, exp_cf2, exp_cf3, out_ready,
    input  in_ready, out_valid, out_sh, acc_cnt
  );
endinterface

// File: rtl/masked_share_compress.sv
// Captures expanded shares of the SKINNY second-order masked coordinate
// functions behind a glitch barrier and compresses each coordinate to 3 shares.
module masked_share_compress #(
  parameter int PIPE_OUT = 1,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  masked_share_compress_if.slave  bus
);

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // Valid never depends on ready; ready drops only when every stage is full.
  logic             r_s1_valid;
  logic [26:0]      r_cf0;
  logic [26:0]      r_cf1;
  logic [8:0]       r_cf2;
  logic [8:0]       r_cf3;
  logic [CNT_W-1:0] r_acc_cnt;

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_s1_drain;
  logic [11:0]      w_cmp;

  assign w_in_fire = bus.in_valid && w_in_ready;

  // Stage 1 is the glitch barrier: only the enable mux sits before these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_cf0      <= '0;
      r_cf1      <= '0;
      r_cf2      <= '0;
      r_cf3      <= '0;
    end else if (bus.flush) begin
      r_s1_valid <= 1'b0;
      r_cf0      <= '0;
      r_cf1      <= '0;
      r_cf2      <= '0;
      r_cf3      <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_cf0      <= bus.exp_cf0;
      r_cf1      <= bus.exp_cf1;
      r_cf2      <= bus.exp_cf2;
      r_cf3      <= bus.exp_cf3;
    end else if (w_s1_drain) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= '0;
    end else if (w_in_fire && !bus.flush) begin
      r_acc_cnt <= r_acc_cnt + CNT_W'(1);
    end
  end

  // Each output share folds only the expanded shares of the same share index.
  always_comb begin
    w_cmp = '0;
    for (int j = 0; j < 3; j++) begin
      w_cmp[4*j+0] = ^r_cf0[9*j +: 9];
      w_cmp[4*j+1] = ^r_cf1[9*j +: 9];
      w_cmp[4*j+2] = ^r_cf2[3*j +: 3];
      w_cmp[4*j+3] = ^r_cf3[3*j +: 3];
    end
  end

  assign bus.acc_cnt  = r_acc_cnt;
  assign bus.in_ready = w_in_ready;

  if (PIPE_OUT != 0) begin : g_pipe
    logic        r_s2_valid;
    logic [11:0] r_s2_sh;
    logic        w_s2_take;

    assign w_s2_take  = r_s1_valid && (!r_s2_valid || bus.out_ready);
    assign w_s1_drain = w_s2_take;
    assign w_in_ready = !r_s1_valid || !r_s2_valid || bus.out_ready;

    // On drain the share value is kept so the output wires do not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_valid <= 1'b0;
        r_s2_sh    <= '0;
      end else if (bus.flush) begin
        r_s2_valid <= 1'b0;
        r_s2_sh    <= '0;
      end else if (w_s2_take) begin
        r_s2_valid <= 1'b1;
        r_s2_sh    <= w_cmp;
      end else if (bus.out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_sh    = r_s2_sh;
  end else begin : g_comb
    assign w_s1_drain    = bus.out_ready;
    assign w_in_ready    = !r_s1_valid || bus.out_ready;
    assign bus.out_valid = r_s1_valid;
    assign bus.out_sh    = w_cmp;
  end

endmodule

// File: tb/tb_masked_share_compress.sv
// Directed bench for masked_share_compress: a queue-based model checks the
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_masked_share_compress;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_share_compress_if #(.CNT_W(CNT_W)) bus ();

  masked_share_compress #(.PIPE_OUT(1), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: contents in flight, in order, with the cycle each was accepted.
  logic [11:0]      exp_q[$];
  int               acc_q[$];
  int               cyc = 0;
  int               last_del = -10;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_v;
  logic             m_r;

  logic [26:0] b2b_c0[4] = '{27'h0000001, 27'h5555555, 27'h00001FF, 27'h7FC0000};
  logic [26:0] b2b_c1[4] = '{27'h7FFFFFF, 27'h0000003, 27'h0040200, 27'h2AAAAAA};
  logic [8:0]  b2b_c2[4] = '{9'h1FF, 9'h049, 9'h100, 9'h007};
  logic [8:0]  b2b_c3[4] = '{9'h001, 9'h0F0, 9'h155, 9'h038};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_compress(input logic [26:0] c0, input logic [26:0] c1,
                                                 input logic [8:0] c2, input logic [8:0] c3);
    logic [11:0] r;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 9; k++) begin
        r[4*j+0] = r[4*j+0] ^ c0[9*j+k];
        r[4*j+1] = r[4*j+1] ^ c1[9*j+k];
      end
      for (int k = 0; k < 3; k++) begin
        r[4*j+2] = r[4*j+2] ^ c2[3*j+k];
        r[4*j+3] = r[4*j+3] ^ c3[3*j+k];
      end
    end
    return r;
  endfunction

  // An item is visible two cycles after acceptance, and never before the
  // cycle following the delivery of its predecessor.
  function automatic logic model_out_valid();
    int vis;
    if (exp_q.size() == 0) return 1'b0;
    vis = acc_q[0] + 2;
    if (last_del + 1 > vis) vis = last_del + 1;
    return (cyc >= vis);
  endfunction

  function automatic logic model_in_ready();
    return (exp_q.size() < 2) || bus.out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      m_cnt = '0;
      last_del = -10;
      cyc = 0;
    end else begin
      m_v = model_out_valid();
      m_r = model_in_ready();
      if (bus.flush) begin
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (m_v && bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          last_del = cyc;
        end
        if (bus.in_valid && m_r) begin
          exp_q.push_back(model_compress(bus.exp_cf0, bus.exp_cf1, bus.exp_cf2, bus.exp_cf3));
          acc_q.push_back(cyc);
          m_cnt = m_cnt + 1'b1;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(model_out_valid()));
      chk("in_ready", 32'(bus.in_ready), 32'(model_in_ready()));
      chk("acc_cnt", 32'(bus.acc_cnt), 32'(m_cnt));
      if (model_out_valid()) chk("out_sh", 32'(bus.out_sh), 32'(exp_q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [26:0] c0, input logic [26:0] c1,
                       input logic [8:0] c2, input logic [8:0] c3);
    bus.in_valid = v;
    bus.exp_cf0  = c0;
    bus.exp_cf1  = c1;
    bus.exp_cf2  = c2;
    bus.exp_cf3  = c3;
  endtask

  task automatic idle();
    drive(1'b0, 27'h0, 27'h0, 9'h0, 9'h0);
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_sh", 32'(bus.out_sh), 32'h0);
    chk("rst_acc_cnt", 32'(bus.acc_cnt), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    step();

    // single transfer, cubic all-ones
    drive(1'b1, 27'h7FFFFFF, 27'h0, 9'h0, 9'h0);
    step();
    idle();
    @(negedge clk);
    chk("t1_early_valid", 32'(bus.out_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_sh", 32'(bus.out_sh), 32'h111);
    chk("t1_cnt", 32'(bus.acc_cnt), 32'd1);
    step();

    // quadratic grouping
    drive(1'b1, 27'h0, 27'h0, 9'b000_000_111, 9'b101_000_001);
    step();
    idle();
    step();
    @(negedge clk);
    chk("t2_valid", 32'(bus.out_valid), 32'h1);
    chk("t2_sh", 32'(bus.out_sh), 32'h00C);
    chk("t2_cnt", 32'(bus.acc_cnt), 32'd2);
    step();

    // back-to-back with out_ready high
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, b2b_c0[k], b2b_c1[k], b2b_c2[k], b2b_c3[k]);
      @(negedge clk);
      chk("b2b_in_ready", 32'(bus.in_ready), 32'h1);
      step();
    end
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("b2b_cnt", 32'(bus.acc_cnt), 32'd6);
    step();

    // backpressure: A, B accepted, C blocked
    bus.out_ready = 1'b0;
    drive(1'b1, 27'h0000007, 27'h0, 9'b001_000_000, 9'h0);
    step();
    drive(1'b1, 27'h0, 27'h0000200, 9'h0, 9'h0);
    step();
    drive(1'b1, 27'h0, 27'h0, 9'h0, 9'b000_010_000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_sh", 32'(bus.out_sh), 32'h401);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_cnt", 32'(bus.acc_cnt), 32'd8);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    idle();
    @(negedge clk);
    chk("bp_rel_sh_b", 32'(bus.out_sh), 32'h020);
    step();
    @(negedge clk);
    chk("bp_rel_sh_c", 32'(bus.out_sh), 32'h080);
    chk("bp_rel_cnt", 32'(bus.acc_cnt), 32'd9);
    repeat (2) step();

    // flush with both stages full and an input offered
    bus.out_ready = 1'b0;
    drive(1'b1, 27'h1234567, 27'h0ABCDEF, 9'h1A5, 9'h05A);
    step();
    drive(1'b1, 27'h7654321, 27'h0FEDCBA, 9'h0C3, 9'h13C);
    step();
    drive(1'b1, 27'h7FFFFFF, 27'h7FFFFFF, 9'h1FF, 9'h1FF);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    chk("fl_out_valid", 32'(bus.out_valid), 32'h0);
    chk("fl_out_sh", 32'(bus.out_sh), 32'h000);
    chk("fl_in_ready", 32'(bus.in_ready), 32'h1);
    chk("fl_cnt", 32'(bus.acc_cnt), 32'd11);
    bus.out_ready = 1'b1;
    step();

    // counter wrap after 256 accepts
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 27'($urandom()), 27'($urandom()), 9'($urandom()), 9'($urandom()));
      step();
    end
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("wrap_cnt", 32'(bus.acc_cnt), 32'd11);
    step();

    // async reset during a stall
    bus.out_ready = 1'b0;
    drive(1'b1, 27'h0000100, 27'h0, 9'h0, 9'h0);
    step();
    drive(1'b1, 27'h0, 27'h4000000, 9'h0, 9'h0);
    step();
    idle();
    step();
    @(negedge clk);
    chk("ar_pre_valid", 32'(bus.out_valid), 32'h1);
    chk("ar_pre_sh", 32'(bus.out_sh), 32'h001);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_out_sh", 32'(bus.out_sh), 32'h000);
    chk("ar_cnt", 32'(bus.acc_cnt), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    drive(1'b1, 27'h7FFFFFF, 27'h0, 9'h0, 9'h0);
    step();
    idle();
    step();
    @(negedge clk);
    chk("ar_post_sh", 32'(bus.out_sh), 32'h111);
    chk("ar_post_cnt", 32'(bus.acc_cnt), 32'd1);
    repeat (2) step();

    summary();
    $finish;
  end

endmodule

// File: doc/masked_share_compress.md
Name: masked_share_compress

Overview:
- Receiving end of the expanded-share interface driven by the SKINNY second-order masked coordinate functions.
- Captures the 27-share outputs of the two cubic coordinate functions (Co_f 0/1) and the 9-share outputs of the two quadratic coordinate functions (Co_f 2/3) in a glitch-barrier register.
- Compresses each coordinate back to 3 output shares.
- Delivers the result through a valid/ready pipeline to the next S-box stage.

Parameters:
- PIPE_OUT, 1, 1 = compressed shares registered (2-cycle latency); 0 = compression XOR driven directly from the stage-1 register (1-cycle latency).
- CNT_W, 8, width of the accepted-transaction counter.

Ports:
- clk  in  1  clock, all flops rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all in-flight data
- in_valid  in  1  expanded shares present
- in_ready  out  1  block can accept this cycle
- exp_cf0  in  27  expanded shares, cubic coordinate 0 (q of num 0..26 at bit num)
- exp_cf1  in  27  expanded shares, cubic coordinate 1
- exp_cf2  in  9  expanded shares, quadratic coordinate 2
- exp_cf3  in  9  expanded shares, quadratic coordinate 3
- out_valid  out  1  compressed shares present
- out_ready  in  1  downstream accepts
- out_sh  out  12  out_sh[4*j+i] = share j (0..2) of coordinate i (0..3)
- acc_cnt  out  CNT_W  number of accepted input transfers, wraps

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, all share registers=0, out_sh=0, out_valid=0, acc_cnt=0. in_ready=1 once reset is released.
- Stage 1 (glitch barrier): on in_valid&&in_ready, register exp_cf0..3 unmodified.
  - No logic is permitted between input ports and these flops other than the enable mux.
- Compression, computed only from stage-1 flops:
  - Cubic, j in 0..2: share j = XOR of exp_cf[9j+8 : 9j].
  - Quadratic, j in 0..2: share j = XOR of exp_cf[3j+2 : 3j].
  - XOR order within a group is irrelevant; groups must never mix bits across share index j.
- PIPE_OUT=1:
  - Stage 2 captures the compressed 12 bits when s1_valid && (!s2_valid || out_ready).
  - out_sh and out_valid come from stage-2 flops.
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - Latency from accepting edge to out_valid high: 2 cycles.
  - Full throughput of one transfer per cycle while out_ready=1.
- PIPE_OUT=0:
  - out_valid = s1_valid; out_sh = compression of stage 1.
  - in_ready = !s1_valid || out_ready.
  - Latency: 1 cycle.
- Stall (out_valid && !out_ready): out_sh is held bit-stable and all registers hold.
  - in_ready deasserts only when every stage is occupied.
  - A held share must not toggle, which is a side-channel requirement.
- Register handling when a stage empties (handshake completes with no new data): share registers keep their last value. Valid drops; data is not zeroed, to avoid extra transitions.
- acc_cnt increments by 1 on every in_valid&&in_ready. It wraps from 2^CNT_W-1 to 0.
- flush (synchronous, priority over all handshakes):
  - Next edge sets every valid=0 and every share register=0.
  - acc_cnt is not affected.
  - An input offered in the flush cycle is dropped and not counted.
- rst_n asserted mid-transfer: immediate clear as for reset. No partial output is presented.
- Simultaneous out_ready and in_valid with both stages full: the pipeline shifts and the new data is accepted in the same cycle.
- The block never reorders transfers and never drops data except on flush or reset.

Test Plan:
- Reset then single transfer, PIPE_OUT=1: exp_cf0=27'h7FFFFFF, others 0 -> out_valid high 2 cycles after accept, out_sh=12'h111, acc_cnt=1.
- Quadratic grouping: exp_cf2=9'b000_000_111, exp_cf3=9'b101_000_001, others 0 -> out_sh=12'h00C (share0 bits 2,3 = 1; share2 bit3 = 1+1 = 0); unmasked XOR over j per bit = 4'b1100.
- Back-to-back 4 transfers with out_ready=1 -> 4 consecutive out_valid cycles in order, in_ready constantly 1, acc_cnt=4.
- Backpressure: out_ready=0 for 5 cycles after 3 offers -> 2 accepted, in_ready=0 afterwards, out_sh bit-stable throughout; out_ready=1 releases the transfers in order.
- Flush while both stages full and in_valid=1 -> next cycle out_valid=0, out_sh=12'h000, in_ready=1, acc_cnt unchanged.
- Async reset mid-stall, plus acc_cnt wrap: 256 accepts return acc_cnt to 0; rst_n pulse between edges clears out_valid immediately without waiting for a clock edge.
